// File: rtl/anton_neopixel_apb_streamer.sv
// anton_neopixel_apb_streamer: turns a byte stream into neopixel APB pixel writes plus one control write per frame.
// Optional read-back verify of every pixel write is enabled by defining ANTON_NEOPIXEL_STREAMER_VERIFY_EN.
module anton_neopixel_apb_streamer #(
    parameter logic [12:0] BUFFER_END = 13'd31,
    parameter logic [12:0] CTRL_REG   = 13'd0,
    parameter logic [7:0]  CTRL_VALUE = 8'h01
) (
    input  logic        apbPclk,
    input  logic        apbPreset,
    input  logic        enable,
    input  logic [7:0]  streamData,
    input  logic        streamValid,
    input  logic        streamLast,
    output logic        streamReady,
    output logic [15:0] apbPaddr,
    output logic [7:0]  apbPwData,
    output logic        apbPselx,
    output logic        apbPenable,
    output logic        apbPwrite,
    input  logic [7:0]  apbPrData,
    input  logic        apbPready,
    input  logic        apbPslverr,
    output logic        frameDone,
    output logic        busy,
    output logic [7:0]  errorCount
`ifdef ANTON_NEOPIXEL_STREAMER_VERIFY_EN
    ,
    output logic [7:0]  mismatchCount
`endif
);
    typedef enum logic [2:0] {
        IDLE, D_SETUP, D_ACCESS, C_SETUP, C_ACCESS
`ifdef ANTON_NEOPIXEL_STREAMER_VERIFY_EN
        , R_SETUP, R_ACCESS
`endif
    } state_t;

    state_t      r_state, w_next, w_after_data;
    logic [12:0] r_addr;
    logic [7:0]  r_data, r_err;
    logic        r_last;
    logic        w_accept, w_eof, w_access, w_data_done;
    logic        w_sel, w_en, w_wr, w_ctl;
    logic [15:0] w_paddr;
    logic [7:0]  w_wdata;

    assign streamReady = enable && r_state == IDLE;
    assign busy        = r_state != IDLE;
    assign frameDone   = r_state == C_ACCESS && apbPready;
    assign errorCount  = r_err;
    assign w_accept    = streamValid && streamReady;
    assign w_eof       = r_last || r_addr == BUFFER_END;

`ifdef ANTON_NEOPIXEL_STREAMER_VERIFY_EN
    logic [7:0] r_mm;
    assign mismatchCount = r_mm;
    assign w_access      = apbPready && (r_state == D_ACCESS || r_state == C_ACCESS || r_state == R_ACCESS);
    assign w_data_done   = apbPready && r_state == R_ACCESS;
    assign w_after_data  = R_SETUP;
    assign w_en          = w_next == D_ACCESS || w_next == C_ACCESS || w_next == R_ACCESS;
    always_ff @(posedge apbPclk) begin
        if (apbPreset)
            r_mm <= '0;
        else if (w_data_done && apbPrData != r_data && r_mm != 8'hFF)
            r_mm <= r_mm + 8'd1;
    end
`else
    logic w_unused;
    assign w_unused     = ^apbPrData;
    assign w_access     = apbPready && (r_state == D_ACCESS || r_state == C_ACCESS);
    assign w_data_done  = apbPready && r_state == D_ACCESS;
    assign w_after_data = w_eof ? C_SETUP : IDLE;
    assign w_en         = w_next == D_ACCESS || w_next == C_ACCESS;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = w_accept ? D_SETUP : IDLE;
            D_SETUP:  w_next = D_ACCESS;
            D_ACCESS: w_next = apbPready ? w_after_data : D_ACCESS;
            C_SETUP:  w_next = C_ACCESS;
            C_ACCESS: w_next = apbPready ? IDLE : C_ACCESS;
`ifdef ANTON_NEOPIXEL_STREAMER_VERIFY_EN
            R_SETUP:  w_next = R_ACCESS;
            R_ACCESS: w_next = apbPready ? (w_eof ? C_SETUP : IDLE) : R_ACCESS;
`endif
            default:  w_next = IDLE;
        endcase
    end

    // APB outputs are registered from the next state so they line up with the state they describe
    assign w_sel   = w_next != IDLE;
    assign w_ctl   = w_next == C_SETUP || w_next == C_ACCESS;
    assign w_wr    = w_next == D_SETUP || w_next == D_ACCESS || w_ctl;
    assign w_paddr = !w_sel ? 16'h0 : w_ctl ? {1'b1, CTRL_REG, 2'b00} : {1'b0, r_addr, 2'b00};
    assign w_wdata = !w_wr ? 8'h0 : w_ctl ? CTRL_VALUE : (r_state == IDLE ? streamData : r_data);

    always_ff @(posedge apbPclk) begin
        if (apbPreset) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_data     <= '0;
            r_last     <= 1'b0;
            r_err      <= '0;
            apbPselx   <= 1'b0;
            apbPenable <= 1'b0;
            apbPwrite  <= 1'b0;
            apbPaddr   <= '0;
            apbPwData  <= '0;
        end else begin
            r_state    <= w_next;
            apbPselx   <= w_sel;
            apbPenable <= w_en;
            apbPwrite  <= w_wr;
            apbPaddr   <= w_paddr;
            apbPwData  <= w_wdata;
            if (w_accept) begin
                r_data <= streamData;
                r_last <= streamLast;
            end
            if (w_access && apbPslverr && r_err != 8'hFF)
                r_err <= r_err + 8'd1;
            if (frameDone)
                r_addr <= '0;
            else if (w_data_done && !w_eof)
                r_addr <= r_addr + 13'd1;
        end
    end
endmodule

// File: tb/tb_anton_neopixel_apb_streamer.sv
// tb_anton_neopixel_apb_streamer: randomized stream stimulus checked against a queue-based frame model.
module tb_anton_neopixel_apb_streamer;
    logic        clk = 1'b0;
    logic        apbPreset, enable, streamValid, streamLast, apbPready, apbPslverr;
    logic [7:0]  streamData, apbPrData;
    logic        streamReady, apbPselx, apbPenable, apbPwrite, frameDone, busy;
    logic [15:0] apbPaddr;
    logic [7:0]  apbPwData, errorCount;
`ifdef ANTON_NEOPIXEL_STREAMER_VERIFY_EN
    logic [7:0]  mismatchCount;
`endif

    anton_neopixel_apb_streamer dut (
        .apbPclk(clk), .apbPreset(apbPreset), .enable(enable),
        .streamData(streamData), .streamValid(streamValid), .streamLast(streamLast),
        .streamReady(streamReady), .apbPaddr(apbPaddr), .apbPwData(apbPwData),
        .apbPselx(apbPselx), .apbPenable(apbPenable), .apbPwrite(apbPwrite),
        .apbPrData(apbPrData), .apbPready(apbPready), .apbPslverr(apbPslverr),
        .frameDone(frameDone), .busy(busy), .errorCount(errorCount)
`ifdef ANTON_NEOPIXEL_STREAMER_VERIFY_EN
        , .mismatchCount(mismatchCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {logic [15:0] a; logic [7:0] d; logic w; int t;} xfer_t;
    xfer_t       obs[$];
    logic [23:0] exp[$];
    int checks = 0, fails = 0, cyc = 0, done_cnt = 0, exp_done = 0, m_addr = 0;
    logic rand_ready = 1'b0;

    // Bus monitor: a transfer completes on the edge after a negedge that sees ACCESS with ready
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!apbPreset && apbPselx && apbPenable && apbPready) obs.push_back('{apbPaddr, apbPwData, apbPwrite, cyc});
        if (!apbPreset && frameDone) done_cnt++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) apbPready = 1'($urandom_range(0, 1));
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    // Reference model: each byte lands at its pixel address; a frame ends on last or at byte 31
    task automatic send_byte(input logic [7:0] d, input logic l);
        int n = 0;
        streamData = d;
        streamLast = l;
        streamValid = 1'b1;
        @(negedge clk);
        while (!streamReady && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!streamReady) begin
            fails++;
            $display("FAIL send_byte timeout: streamReady=%b expected 1", streamReady);
        end
        @(posedge clk);
        #1 streamValid = 1'b0;
        exp.push_back({16'(m_addr * 4), d});
        if (l || m_addr == 31) begin
            exp.push_back({16'h8000, 8'h01});
            m_addr = 0;
            exp_done++;
        end else m_addr++;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy) begin
            fails++;
            $display("FAIL wait_idle timeout: busy=%b expected 0", busy);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apbPreset = 1'b1; enable = 1'b0; streamValid = 1'b0; streamLast = 1'b0; streamData = 8'h0;
        apbPready = 1'b1; apbPslverr = 1'b0; apbPrData = 8'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({apbPselx, apbPenable, apbPwrite, apbPaddr, apbPwData} !== 27'h0) begin
            fails++;
            $display("FAIL reset_apb: got sel%b en%b wr%b %h/%h expected all 0", apbPselx, apbPenable, apbPwrite, apbPaddr, apbPwData);
        end
        checks++;
        if ({streamReady, frameDone, busy, errorCount} !== 11'h0) begin
            fails++;
            $display("FAIL reset_status: got rdy%b done%b busy%b err%0d expected 0", streamReady, frameDone, busy, errorCount);
        end
        apbPreset = 1'b0;
        @(negedge clk);
        checks++;
        if (streamReady !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready_disabled: got %b expected 0", streamReady);
        end
        enable = 1'b1;
        #1;
        checks++;
        if (streamReady !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready_enabled: got %b expected 1", streamReady);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_frame();
        int d0 = done_cnt;
        for (int i = 0; i < 32; i++) send_byte(8'(i), 1'b0);
        send_byte(8'hEE, 1'b0);
        wait_idle();
        checks++;
        if (obs.size() != exp.size()) begin
            fails++;
            $display("FAIL full_frame count: got %0d expected %0d", obs.size(), exp.size());
        end
        foreach (exp[i]) if (i < obs.size()) begin
            checks++;
            if ({obs[i].a, obs[i].d, obs[i].w} !== {exp[i], 1'b1}) begin
                fails++;
                $display("FAIL full_frame xfer %0d: got %h/%h w%b expected %h/%h w1", i, obs[i].a, obs[i].d, obs[i].w, exp[i][23:8], exp[i][7:0]);
            end
        end
        if (obs.size() >= 33) for (int i = 1; i < 33; i++) begin
            checks++;
            if (obs[i].t - obs[i-1].t != (i == 32 ? 2 : 3)) begin
                fails++;
                $display("FAIL full_frame spacing %0d: got %0d cycles expected %0d", i, obs[i].t - obs[i-1].t, i == 32 ? 2 : 3);
            end
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            fails++;
            $display("FAIL full_frame frameDone: got %0d pulses expected 1", done_cnt - d0);
        end
        obs.delete(); exp.delete();
    endtask

    task automatic test_short_frame();
        int d0 = done_cnt, e0 = exp_done;
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), i == 4);
        send_byte(8'($urandom), 1'b1);
        wait_idle();
        checks++;
        if (obs.size() != exp.size()) begin
            fails++;
            $display("FAIL short_frame count: got %0d expected %0d", obs.size(), exp.size());
        end
        foreach (exp[i]) if (i < obs.size()) begin
            checks++;
            if ({obs[i].a, obs[i].d, obs[i].w} !== {exp[i], 1'b1}) begin
                fails++;
                $display("FAIL short_frame xfer %0d: got %h/%h w%b expected %h/%h w1", i, obs[i].a, obs[i].d, obs[i].w, exp[i][23:8], exp[i][7:0]);
            end
        end
        checks++;
        if (done_cnt - d0 != exp_done - e0) begin
            fails++;
            $display("FAIL short_frame frameDone: got %0d pulses expected %0d", done_cnt - d0, exp_done - e0);
        end
        obs.delete(); exp.delete();
    endtask

    task automatic test_wait_states();
        logic [15:0] a = 16'(m_addr * 4);
        apbPready = 1'b0;
        send_byte(8'hA5, 1'b0);
        @(negedge clk);
        checks++;
        if ({apbPselx, apbPenable, apbPwrite} !== 3'b101) begin
            fails++;
            $display("FAIL wait_setup: got sel/en/wr %b%b%b expected 101", apbPselx, apbPenable, apbPwrite);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({apbPenable, apbPaddr, apbPwData, streamReady, obs.size() == 0} !== {1'b1, a, 8'hA5, 1'b0, 1'b1}) begin
                fails++;
                $display("FAIL wait_hold %0d: got en%b %h/%h rdy%b n%0d expected en1 %h/a5 rdy0 n0", k, apbPenable, apbPaddr, apbPwData, streamReady, obs.size(), a);
            end
        end
        @(posedge clk);
        #1 apbPready = 1'b1;
        @(negedge clk);
        checks++;
        if (obs.size() != 1 || apbPenable !== 1'b1) begin
            fails++;
            $display("FAIL wait_complete: got n%0d en%b expected n1 en1", obs.size(), apbPenable);
        end
        wait_idle();
        checks++;
        if (obs.size() != 1 || exp.size() != 1 || (obs.size() == 1 && {obs[0].a, obs[0].d} !== exp[0])) begin
            fails++;
            $display("FAIL wait_xfer: got %0d transfers expected 1 to %h", obs.size(), a);
        end
        obs.delete(); exp.delete();
    endtask

    task automatic test_boundary();
        int d0 = done_cnt, e0 = exp_done;
        while (m_addr != 31) send_byte(8'($urandom), 1'b0);
        send_byte(8'h5A, 1'b1);
        wait_idle();
        checks++;
        if (obs.size() != exp.size()) begin
            fails++;
            $display("FAIL boundary count: got %0d expected %0d", obs.size(), exp.size());
        end
        foreach (exp[i]) if (i < obs.size()) begin
            checks++;
            if ({obs[i].a, obs[i].d, obs[i].w} !== {exp[i], 1'b1}) begin
                fails++;
                $display("FAIL boundary xfer %0d: got %h/%h w%b expected %h/%h w1", i, obs[i].a, obs[i].d, obs[i].w, exp[i][23:8], exp[i][7:0]);
            end
        end
        checks++;
        if (done_cnt - d0 != exp_done - e0) begin
            fails++;
            $display("FAIL boundary frameDone: got %0d pulses expected %0d", done_cnt - d0, exp_done - e0);
        end
        obs.delete(); exp.delete();
    endtask

    task automatic test_slverr();
        apbPslverr = 1'b1;
        for (int i = 0; i < 100; i++) send_byte(8'($urandom), 1'b0);
        wait_idle();
        checks++;
        if (errorCount !== 8'(exp.size() > 255 ? 255 : exp.size())) begin
            fails++;
            $display("FAIL slverr_partial: got %0d expected %0d", errorCount, exp.size());
        end
        for (int i = 0; i < 200; i++) send_byte(8'($urandom), 1'b0);
        wait_idle();
        checks++;
        if (errorCount !== 8'(exp.size() > 255 ? 255 : exp.size())) begin
            fails++;
            $display("FAIL slverr_saturate: got %0d expected 255 after %0d transfers", errorCount, exp.size());
        end
        checks++;
        if (obs.size() != exp.size()) begin
            fails++;
            $display("FAIL slverr count: got %0d expected %0d", obs.size(), exp.size());
        end
        obs.delete(); exp.delete();
        apbPslverr = 1'b0;
        apbPreset = 1'b1;
        @(posedge clk);
        #1 apbPreset = 1'b0;
        m_addr = 0;
        @(negedge clk);
        checks++;
        if ({errorCount, apbPselx, busy, streamReady} !== {8'h0, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL slverr_reset: got err%0d sel%b busy%b rdy%b expected err0 sel0 busy0 rdy1", errorCount, apbPselx, busy, streamReady);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int d0;
        for (int i = 0; i < 10; i++) send_byte(8'(8'h40 + i), 1'b0);
        wait_idle();
        obs.delete(); exp.delete();
        apbPready = 1'b0;
        send_byte(8'h4A, 1'b0);
        exp.delete();
        m_addr = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({apbPenable, apbPaddr} !== {1'b1, 16'h0028}) begin
            fails++;
            $display("FAIL reset_mid_access: got en%b %h expected en1 0028", apbPenable, apbPaddr);
        end
        @(posedge clk);
        #1 apbPreset = 1'b1;
        @(posedge clk);
        #1 apbPreset = 1'b0;
        apbPready = 1'b1;
        obs.delete();
        d0 = done_cnt;
        send_byte(8'h77, 1'b0);
        wait_idle();
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (obs.size() != 1 || (obs.size() == 1 && {obs[0].a, obs[0].d} !== exp[0]) || done_cnt != d0) begin
            fails++;
            $display("FAIL reset_mid_resume: got %0d transfers first %h done%0d expected 1 transfer to 0000 done0", obs.size(), obs.size() > 0 ? obs[0].a : 16'hxxxx, done_cnt - d0);
        end
        obs.delete(); exp.delete();
    endtask

    task automatic test_enable();
        send_byte(8'h11, 1'b0);
        enable = 1'b0;
        wait_idle();
        checks++;
        if (obs.size() != 1) begin
            fails++;
            $display("FAIL enable_inflight: got %0d transfers expected 1", obs.size());
        end
        streamData = 8'h3C;
        streamValid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({streamReady, busy} !== 2'b00) begin
                fails++;
                $display("FAIL enable_low %0d: got rdy%b busy%b expected 00", k, streamReady, busy);
            end
        end
        @(posedge clk);
        #1 enable = 1'b1;
        send_byte(8'h3C, 1'b0);
        send_byte(8'h3D, 1'b1);
        wait_idle();
        checks++;
        if (obs.size() != exp.size()) begin
            fails++;
            $display("FAIL enable count: got %0d expected %0d", obs.size(), exp.size());
        end
        foreach (exp[i]) if (i < obs.size()) begin
            checks++;
            if ({obs[i].a, obs[i].d, obs[i].w} !== {exp[i], 1'b1}) begin
                fails++;
                $display("FAIL enable xfer %0d: got %h/%h w%b expected %h/%h w1", i, obs[i].a, obs[i].d, obs[i].w, exp[i][23:8], exp[i][7:0]);
            end
        end
        obs.delete(); exp.delete();
    endtask

    task automatic test_random_frames();
        int d0 = done_cnt, e0 = exp_done, len;
        rand_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            len = (f == 0) ? 1 : int'($urandom_range(1, 40));
            for (int b = 0; b < len; b++) send_byte(8'($urandom), b == len - 1);
        end
        wait_idle();
        rand_ready = 1'b0;
        @(posedge clk);
        #1 apbPready = 1'b1;
        checks++;
        if (obs.size() != exp.size()) begin
            fails++;
            $display("FAIL random count: got %0d expected %0d", obs.size(), exp.size());
        end
        foreach (exp[i]) if (i < obs.size()) begin
            checks++;
            if ({obs[i].a, obs[i].d, obs[i].w} !== {exp[i], 1'b1}) begin
                fails++;
                $display("FAIL random xfer %0d: got %h/%h w%b expected %h/%h w1", i, obs[i].a, obs[i].d, obs[i].w, exp[i][23:8], exp[i][7:0]);
            end
        end
        checks++;
        if (done_cnt - d0 != exp_done - e0) begin
            fails++;
            $display("FAIL random frameDone: got %0d pulses expected %0d", done_cnt - d0, exp_done - e0);
        end
        obs.delete(); exp.delete();
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_short_frame();
        test_wait_states();
        test_boundary();
        test_slverr();
        test_reset_mid();
        test_enable();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/anton_neopixel_apb_streamer.md
Name: anton_neopixel_apb_streamer

Overview:
- APB master stage directly upstream of the neopixel APB slave.
- Accepts a byte stream (valid/ready with a last flag) and writes each byte to consecutive pixel-buffer addresses: byte address N appears as word address N<<2.
- At the end of each frame it issues one control-register write (apbPaddr[15]=1), which tells the neopixel block to display the frame.
- Replaces CPU-driven pixel writes with a hardware stream source such as a DMA or pattern generator.

Parameters:
- BUFFER_END, 31, index of the last pixel byte; frame wraps after this byte; maximum 8191.
- CTRL_REG, 0, control register index; placed in apbPaddr[14:2] during the control write.
- CTRL_VALUE, 8'h01, data byte written to the control register at end of frame.

Ports:
- apbPclk  input  1  single clock for the whole block and the APB bus.
- apbPreset  input  1  synchronous, active-high reset.
- enable  input  1  when low, no new stream bytes are accepted; a transfer already in progress completes.
- streamData  input  8  pixel byte.
- streamValid  input  1  streamData is valid.
- streamLast  input  1  qualifies the final byte of a frame.
- streamReady  output  1  block can accept a byte this cycle.
- apbPaddr  output  16  APB address.
- apbPwData  output  8  APB write data.
- apbPselx  output  1  APB select.
- apbPenable  output  1  APB enable.
- apbPwrite  output  1  APB write strobe.
- apbPrData  input  8  APB read data; used only with the optional feature.
- apbPready  input  1  slave ready.
- apbPslverr  input  1  slave error.
- frameDone  output  1  one-cycle pulse when the control write completes.
- busy  output  1  high in any state other than IDLE.
- errorCount  output  8  saturating count of transfers that ended with apbPslverr=1.

Behaviour:
- Reset values: all APB outputs 0, streamReady 0, frameDone 0, busy 0, errorCount 0, pixel address counter 0, state IDLE. Reset aborts any transfer in progress, including mid-ACCESS.
- streamReady = enable && state==IDLE. It is purely combinational from the registered state.
- IDLE: on streamValid && streamReady, latch streamData, streamLast and the current address. Next state is D_SETUP.
- D_SETUP (one cycle):
  - apbPselx=1, apbPenable=0, apbPwrite=1.
  - apbPaddr = {1'b0, addr[12:0], 2'b00}; apbPwData = latched byte.
  - Next state is D_ACCESS.
- D_ACCESS:
  - Same address and data, apbPenable=1.
  - Hold the state while apbPready=0.
  - On apbPready=1, if apbPslverr=1, increment errorCount; it saturates at 255.
  - End of frame is latched last=1 OR addr==BUFFER_END.
    - If end of frame: go to C_SETUP.
    - Otherwise: addr <= addr+1 and go to IDLE.
- C_SETUP / C_ACCESS:
  - Same handshake as D_SETUP / D_ACCESS.
  - apbPaddr = {1'b1, CTRL_REG[12:0], 2'b00}; apbPwData = CTRL_VALUE.
  - When C_ACCESS completes: addr <= 0, frameDone=1 for exactly that cycle, next state IDLE. errorCount is updated the same way as for data writes.
- All APB outputs are registered and are 0 in IDLE: apbPselx=0, apbPenable=0, apbPwrite=0, apbPaddr=0, apbPwData=0.
- Throughput: 3 cycles per byte with zero-wait-state slaves (IDLE, SETUP, ACCESS). Each slave wait state adds one cycle.
- Boundary cases:
  - streamLast on the byte at BUFFER_END produces a single control write, not two.
  - A one-byte frame (last on addr 0) is legal.
  - A byte arriving while busy waits because streamReady=0; no data is lost.
- Width: addr is 13 bits; the comparison against BUFFER_END is done at 13 bits.
- Dropping enable mid-frame keeps addr, so the frame resumes at the next address when enable returns.

Optional Feature:
- Macro: ANTON_NEOPIXEL_STREAMER_VERIFY_EN.
- When defined:
  - After each completed D_ACCESS, the block performs an APB read of the same address (R_SETUP, R_ACCESS, with apbPwrite=0).
  - It compares apbPrData, sampled on the cycle apbPready=1, with the written byte.
  - A mismatch increments the extra output mismatchCount[7:0], which saturates and resets to 0.
  - The end-of-frame decision is made after the read completes.
  - Throughput becomes 5 cycles per byte.
- When not defined: no read states exist, the mismatchCount port is absent, and apbPrData is ignored.

Test Plan:
- Stream 32 bytes 8'h00..8'h1F, streamLast=0, apbPready=1 -> 32 writes to apbPaddr 16'h0000..16'h007C with matching data. Then one write of 8'h01 to 16'h8000, frameDone pulses once, addr returns to 0.
- Stream 5 bytes with streamLast on byte 5 -> writes to 0x00..0x10, then the control write. The next frame's first byte goes to 16'h0000.
- Hold apbPready=0 for 3 cycles in D_ACCESS -> apbPaddr, apbPwData and apbPenable stay stable, streamReady stays 0, and the transfer completes on the 4th ACCESS cycle.
- Drive apbPslverr=1 on 300 consecutive transfers -> errorCount saturates at 255. Assert apbPreset for one cycle -> errorCount=0, apbPselx=0, state IDLE.
- Assert apbPreset during D_ACCESS of byte 10 -> the next accepted byte writes to 16'h0000 and no control write is issued.
- VERIFY_EN build: the slave returns the written data XOR 8'h01 for byte 3 -> mismatchCount=1 and exactly one read follows each write.
